pattern_chk_sched: RTL and testbench
====================================

# pattern_chk_sched

Read scheduler and sequence checker for the SSD receive-data FIFO. It pulls a software-specified number of 16-bit words from the FIFO in threshold-gated bursts and compares each word with its predecessor plus a fixed step. It also accumulates error and word statistics and reports the end of the run with a done pulse. It sits between the receive FIFO (read side) and the status/register block.

## Interface
Parameters:
- THRESH, 20, fill level that must be exceeded (fifo_usedw > THRESH) before a full burst starts
- BURST_LEN, 16, maximum words per burst; must satisfy 1 <= BURST_LEN <= THRESH+1
- STEP, 16'h0202, expected increment between consecutive non-zero words

Ports:
- clk  in  1  single clock for all logic
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a run; ignored while busy
- abort  in  1  level; terminates a run
- total_words  in  32  words to consume; sampled on start
- fifo_usedw  in  13  FIFO fill level
- fifo_q  in  16  FIFO read data, valid the cycle after fifo_rdreq
- fifo_rdreq  out  1  registered FIFO read request
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky, set on the first mismatch of a run
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- word_cnt  out  32  words received in the current/last run

## Operation
- States: IDLE, WAIT, BURST, GAP, FLUSH, DONE.
- IDLE to WAIT:
  - Taken on start when total_words != 0.
  - Loads remaining = total_words.
  - Clears err, err_cnt, word_cnt and the reference-valid flag.
- IDLE with start and total_words == 0: go directly to DONE; counters are cleared.
- WAIT to BURST:
  - Taken when fifo_usedw > THRESH, or when fifo_usedw >= remaining (tail rule).
  - Loads burst = min(BURST_LEN, remaining).
- BURST:
  - fifo_rdreq is high for exactly `burst` consecutive cycles.
  - remaining decrements once per request.
  - Then go to GAP.
- GAP: one idle cycle so fifo_usedw reflects the burst. Then WAIT if remaining != 0, else FLUSH.
- FLUSH: one cycle to let the last word's check register. Then DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort:
  - In any non-IDLE state, go to IDLE at the next edge and drop fifo_rdreq at that edge.
  - A word already requested is accepted, and counted and checked, only if its data cycle is the abort cycle itself.
  - No done pulse. err, err_cnt and word_cnt hold.
- Checking, per received word d:
  - word_cnt += 1.
  - If the reference is valid and both prev and d are non-zero: mismatch when d != (prev + STEP) mod 2^16.
  - prev <= d always, and the reference becomes valid.
  - The first word of a run is never compared.
- On a mismatch: err <= 1 and err_cnt += 1, with no wrap at 16'hFFFF.
- start while busy is ignored entirely (no counter clear).

## Timing
- Reset values: fifo_rdreq=0, busy=0, done=0, err=0, err_cnt=0, word_cnt=0; state=IDLE; reference invalid.
- Data path latency:
  - Edge N: fifo_rdreq=1.
  - Cycle N+1: fifo_q valid.
  - Edge N+2: word_cnt, err and err_cnt reflect that word.
- Start latency: start sampled at edge S, busy=1 after S, earliest fifo_rdreq=1 after edge S+2 (WAIT decision).
- Last request at edge L:
  - GAP at L+1, FLUSH at L+2, DONE at L+3.
  - done is high in the cycle after L+3 and busy falls at L+4.
  - All counters are final when done is high.
- fifo_rdreq is never high outside BURST, so the FIFO is never read past total_words.
- Reset is asynchronous mid-run: outputs go to reset values immediately and FIFO contents are untouched.

## Configuration
- DATA_ERR_LOG_EN:
  - When defined, adds outputs first_err_idx[31:0], first_err_exp[15:0] and first_err_act[15:0].
  - They capture the word_cnt index (0-based), the expected value and the actual value of the first mismatch of a run.
  - They are cleared on start and reset, and hold until the next start.
- When not defined, these ports and registers are absent; all other behaviour is identical.

## Test plan
- Clean run: total_words=100, FIFO preloaded with 0x0101, 0x0303, … (step 0x0202) -> done pulse, word_cnt=100, err=0, err_cnt=0, exactly 100 rdreq cycles.
- Single corruption: word 10 replaced by 0x1234 -> err_cnt=2 (word 10 and word 11 both mismatch), err=1; with DATA_ERR_LOG_EN: first_err_idx=10, first_err_act=16'h1234.
- Tail rule: total_words=5, usedw=5 (below THRESH) -> one burst of 5, done, no further rdreq.
- Wrap and zero skip:
  - Sequence 0xFEFE, 0x0100 -> no error (mod 2^16).
  - Sequence 0x0000 inserted mid-stream -> no error on 0x0000, and no error on the following word.
- Abort mid-burst at request 7 of 16 -> fifo_rdreq low next edge, busy low, no done, word_cnt between 6 and 7 per the abort-cycle rule.
- Saturation and start-while-busy:
  - Force 70000 mismatches -> err_cnt holds 16'hFFFF.
  - start pulsed during BURST -> no counter clear, run unaffected.

Source files
------------

// File: rtl/pattern_chk_sched.sv
// pattern_chk_sched: read scheduler and sequence checker for the receive-data FIFO.
// Pulls total_words 16-bit words in threshold-gated bursts and checks each
// non-zero word against its non-zero predecessor plus STEP.
// Optional build macro DATA_ERR_LOG_EN adds first-mismatch capture outputs
// (first_err_idx, first_err_exp, first_err_act).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_WAIT  | waiting for fill level above THRESH or covering the tail
// S_BURST | issuing burst_left read requests (one cycle of lag on entry)
// S_GAP   | one idle cycle so fifo_usedw reflects the burst
// S_FLUSH | one cycle so the last word's check lands
// S_DONE  | done pulse, then back to S_IDLE
module pattern_chk_sched #(
  parameter int unsigned THRESH    = 20,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [15:0] STEP      = 16'h0202
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] total_words,
  input  logic [12:0] fifo_usedw,
  input  logic [15:0] fifo_q,
  output logic        fifo_rdreq,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [31:0] word_cnt
`ifdef DATA_ERR_LOG_EN
  ,
  output logic [31:0] first_err_idx,
  output logic [15:0] first_err_exp,
  output logic [15:0] first_err_act
`endif
);

  localparam logic [31:0] THRESH_W = 32'(THRESH);
  localparam logic [31:0] BURST_W  = 32'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BURST, S_GAP, S_FLUSH, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] remaining;
  logic [31:0] burst_left;
  logic        rd_pend;
  logic [15:0] prev;
  logic        ref_valid;

  logic [31:0] usedw_ext;
  logic        go_burst;
  logic [31:0] burst_init;
  logic        rd_issue;
  logic        run_start;
  logic        take;
  logic [15:0] exp_val;
  logic        mismatch;

  assign usedw_ext  = {19'd0, fifo_usedw};
  assign go_burst   = (usedw_ext > THRESH_W) || (usedw_ext >= remaining);
  assign burst_init = (remaining < BURST_W) ? remaining : BURST_W;
  // A request on the abort cycle would be lost anyway, so never issue one.
  assign rd_issue   = (state == S_BURST) && (burst_left != 32'd0) && !abort;
  assign run_start  = (state == S_IDLE) && start;
  // Words arriving once the FSM is back in IDLE (after abort) are discarded.
  assign take       = rd_pend && (state != S_IDLE);
  assign exp_val    = prev + STEP;
  assign mismatch   = take && ref_valid && (prev != 16'd0) && (fifo_q != 16'd0) &&
                      (fifo_q != exp_val);

  // Next-state decode; abort overrides every non-IDLE transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (total_words == 32'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (go_burst) state_nxt = S_BURST;
      S_BURST: if (burst_left == 32'd0) state_nxt = S_GAP;
      S_GAP:   state_nxt = (remaining != 32'd0) ? S_WAIT : S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Read scheduling: request strobe, word/burst down-counters, status flags.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      fifo_rdreq <= 1'b0;
      rd_pend    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= 32'd0;
      burst_left <= 32'd0;
    end else begin
      fifo_rdreq <= rd_issue;
      rd_pend    <= fifo_rdreq;
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      if (run_start) remaining <= total_words;
      if ((state == S_WAIT) && go_burst) burst_left <= burst_init;
      if (rd_issue) begin
        remaining  <= remaining - 32'd1;
        burst_left <= burst_left - 32'd1;
      end
    end
  end

  // Sequence check and statistics on each received word.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      err       <= 1'b0;
      err_cnt   <= 16'd0;
      word_cnt  <= 32'd0;
      prev      <= 16'd0;
      ref_valid <= 1'b0;
`ifdef DATA_ERR_LOG_EN
      first_err_idx <= 32'd0;
      first_err_exp <= 16'd0;
      first_err_act <= 16'd0;
`endif
    end else if (run_start) begin
      err       <= 1'b0;
      err_cnt   <= 16'd0;
      word_cnt  <= 32'd0;
      ref_valid <= 1'b0;
`ifdef DATA_ERR_LOG_EN
      first_err_idx <= 32'd0;
      first_err_exp <= 16'd0;
      first_err_act <= 16'd0;
`endif
    end else if (take) begin
      word_cnt  <= word_cnt + 32'd1;
      prev      <= fifo_q;
      ref_valid <= 1'b1;
      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`ifdef DATA_ERR_LOG_EN
        if (!err) begin
          first_err_idx <= word_cnt;
          first_err_exp <= exp_val;
          first_err_act <= fifo_q;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pattern_chk_sched.sv
// Self-checking bench for pattern_chk_sched: table-driven runs, hand-written
// abort / start-while-busy / async-reset sequences, randomized runs against a
// list-based reference model, and an error-counter saturation run on a
// second instance running concurrently.
module tb_pattern_chk_sched;

  localparam int unsigned THRESH = 20;
  localparam int unsigned BL     = 16;
  localparam logic [15:0] STEP   = 16'h0202;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RST, start, abort;
  logic [31:0] total_words;
  logic [12:0] fifo_usedw = 13'd0;
  logic [15:0] fifo_q = 16'd0;
  logic        fifo_rdreq, busy, done, err;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
`ifdef DATA_ERR_LOG_EN
  logic [31:0] first_err_idx, fe_idx2;
  logic [15:0] first_err_exp, first_err_act, fe_exp2, fe_act2;
`endif

  pattern_chk_sched #(.THRESH(THRESH), .BURST_LEN(BL), .STEP(STEP)) dut (
    .clk(clk), .RST(RST), .start(start), .abort(abort),
    .total_words(total_words), .fifo_usedw(fifo_usedw), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
`ifdef DATA_ERR_LOG_EN
    , .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
`endif
  );

  // Second instance: long bursts, constant data 0x0001 so every compared word mismatches.
  logic        rst2, start2;
  logic [31:0] tw2;
  logic        rd2, busy2, done2, err2;
  logic [15:0] ec2;
  logic [31:0] wc2;

  pattern_chk_sched #(.THRESH(4000), .BURST_LEN(4001), .STEP(STEP)) dut_sat (
    .clk(clk), .RST(rst2), .start(start2), .abort(1'b0),
    .total_words(tw2), .fifo_usedw(13'h1FFF), .fifo_q(16'h0001),
    .fifo_rdreq(rd2), .busy(busy2), .done(done2), .err(err2),
    .err_cnt(ec2), .word_cnt(wc2)
`ifdef DATA_ERR_LOG_EN
    , .first_err_idx(fe_idx2), .first_err_exp(fe_exp2), .first_err_act(fe_act2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: show-ahead off, data one cycle after the request edge.
  logic [15:0] fq[$];
  logic [15:0] src[$];
  logic [15:0] wdata[$];
  bit fast = 1'b1;
  bit flush_req = 1'b0;
  int uflow = 0;

  always @(posedge clk) begin
    if (flush_req) fq.delete();
    else begin
      if (fifo_rdreq) begin
        if (fq.size() == 0) uflow++;
        else fifo_q <= fq.pop_front();
      end
      if (fast) begin
        while (src.size() > 0) fq.push_back(src.pop_front());
      end else if (src.size() > 0 && $urandom_range(0, 2) == 0) begin
        fq.push_back(src.pop_front());
      end
    end
    fifo_usedw <= (fq.size() > 8191) ? 13'd8191 : 13'(fq.size());
  end

  // Request monitor: counts requests, checks each burst is min(BL, remaining).
  int rd_cnt = 0, done_cnt = 0, run_len = 0, last_rd_cyc = 0, first_rd_cyc = 0;
  int start_cyc = 0, rem_model = 0;
  bit first_seen = 1'b0, mon_chk = 1'b0;

  always @(negedge clk) begin
    if (fifo_rdreq) begin
      rd_cnt++;
      run_len++;
      last_rd_cyc = cyc;
      if (!first_seen) begin
        first_seen   = 1'b1;
        first_rd_cyc = cyc;
      end
    end else if (run_len != 0) begin
      if (mon_chk) begin
        check("burst_len", 32'(run_len), 32'((rem_model < int'(BL)) ? rem_model : int'(BL)));
        rem_model -= run_len;
      end
      run_len = 0;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    int tw; int base; int cidx; int cval;
    int exp_wc; int exp_ec; int exp_err; int exp_fidx; int exp_fexp; int exp_fact;
  } vec_t;

  vec_t vecs[9];

  task automatic flush_fifo();
    src.delete();
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
  endtask

  task automatic do_start(input int tw);
    @(negedge clk);
    total_words = 32'(tw);
    start       = 1'b1;
    first_seen  = 1'b0;
    rem_model   = tw;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_run(input string nm, input int tw, input int exp_ec, input int exp_err,
                            input int rd0, input int d0, input bit chk_lat);
    int t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
    check({nm, "_word_cnt"}, word_cnt, 32'(tw));
    check({nm, "_err_cnt"}, 32'(err_cnt), 32'(exp_ec));
    check({nm, "_err"}, 32'(err), 32'(exp_err));
    if (tw != 0) check({nm, "_done_lat"}, 32'(cyc - last_rd_cyc), 32'd3);
    if (chk_lat && tw != 0) check({nm, "_start_lat"}, 32'(first_rd_cyc - start_cyc), 32'd2);
    @(negedge clk);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check({nm, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
    check({nm, "_rd_cnt"}, 32'(rd_cnt - rd0), 32'(tw));
    check({nm, "_uflow"}, 32'(uflow), 32'd0);
  endtask

  task automatic model(output int ec, output int fidx, output int fexp, output int fact);
    ec = 0; fidx = 0; fexp = 0; fact = 0;
    for (int i = 1; i < wdata.size(); i++) begin
      logic [15:0] e;
      e = wdata[i-1] + STEP;
      if (wdata[i-1] != 16'd0 && wdata[i] != 16'd0 && wdata[i] != e) begin
        if (ec == 0) begin fidx = i; fexp = int'(e); fact = int'(wdata[i]); end
        ec++;
      end
    end
  endtask

  task automatic gen_clean(input int n, input logic [15:0] base, input int cidx,
                           input logic [15:0] cval);
    wdata.delete();
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = base + 16'(i) * STEP;
      if (i == cidx) w = cval;
      wdata.push_back(w);
    end
  endtask

  task automatic preload();
    fast = 1'b1;
    foreach (wdata[i]) src.push_back(wdata[i]);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rdreq"}, 32'(fifo_rdreq), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({nm, "_word_cnt"}, word_cnt, 32'd0);
  endtask

  task automatic main_seq();
    int rd0, d0, k, t, ec, fidx, fexp, fact;
    vecs[0] = '{100, 'h0101, -1, 0,        100, 0, 0, 0,  0,        0};
    vecs[1] = '{100, 'h0101, 10, 'h1234,   100, 2, 1, 10, 'h1515,   'h1234};
    vecs[2] = '{0,   'h0101, -1, 0,        0,   0, 0, 0,  0,        0};
    vecs[3] = '{5,   'h0101, -1, 0,        5,   0, 0, 0,  0,        0};
    vecs[4] = '{2,   'hFEFE, -1, 0,        2,   0, 0, 0,  0,        0};
    vecs[5] = '{20,  'h0101, 8,  0,        20,  0, 0, 0,  0,        0};
    vecs[6] = '{30,  'h0101, 0,  'h1234,   30,  1, 1, 1,  'h1436,   'h0303};
    vecs[7] = '{30,  'h0101, 29, 'hABCD,   30,  1, 1, 29, 'h3B3B,   'hABCD};
    vecs[8] = '{37,  'h0000, -1, 0,        37,  0, 0, 0,  0,        0};

    RST = 1'b1; start = 1'b0; abort = 1'b0; total_words = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge clk);

    // Table-driven runs.
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      gen_clean(vecs[v].tw, 16'(vecs[v].base), vecs[v].cidx, 16'(vecs[v].cval));
      preload();
      rd0 = rd_cnt; d0 = done_cnt; mon_chk = 1'b1;
      do_start(vecs[v].tw);
      finish_run(nm, vecs[v].exp_wc, vecs[v].exp_ec, vecs[v].exp_err, rd0, d0, 1'b1);
`ifdef DATA_ERR_LOG_EN
      check({nm, "_fidx"}, first_err_idx, 32'(vecs[v].exp_fidx));
      check({nm, "_fexp"}, 32'(first_err_exp), 32'(vecs[v].exp_fexp));
      check({nm, "_fact"}, 32'(first_err_act), 32'(vecs[v].exp_fact));
`endif
    end

    // Abort during the 7th request of the first 16-word burst.
    gen_clean(40, 16'h0101, -1, 16'h0);
    preload();
    mon_chk = 1'b0; d0 = done_cnt;
    do_start(40);
    k = 0; t = 0;
    while (k < 7 && t < 200) begin
      @(negedge clk);
      t++;
      if (fifo_rdreq) k++;
    end
    check("abort_reach7", 32'(k), 32'd7);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_rdreq", 32'(fifo_rdreq), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); abort = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_word_cnt", word_cnt, 32'd6);
    check("abort_err", 32'(err), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_fifo_left", 32'(fq.size()), 32'd33);
    flush_fifo();

    // start pulsed mid-burst is ignored; early corruption must survive it.
    gen_clean(60, 16'h0101, 2, 16'h1234);
    preload();
    rd0 = rd_cnt; d0 = done_cnt; mon_chk = 1'b1;
    do_start(60);
    k = 0; t = 0;
    while (k < 20 && t < 400) begin
      @(negedge clk);
      t++;
      if (fifo_rdreq) k++;
    end
    start = 1'b1; total_words = 32'd3;
    @(negedge clk); start = 1'b0;
    finish_run("busy_start", 60, 2, 1, rd0, d0, 1'b1);

    // Asynchronous reset mid-burst.
    gen_clean(50, 16'h0101, 4, 16'h0F0F);
    preload();
    mon_chk = 1'b0;
    do_start(50);
    k = 0; t = 0;
    while (k < 12 && t < 400) begin
      @(negedge clk);
      t++;
      if (fifo_rdreq) k++;
    end
    #2 RST = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk); RST = 1'b0;
    flush_fifo();

    // Randomized runs with a trickling producer.
    for (int r = 0; r < 8; r++) begin
      int tw;
      logic [15:0] base;
      string nm;
      nm = $sformatf("rand%0d", r);
      tw = $urandom_range(1, 300);
      base = 16'($urandom);
      wdata.delete();
      for (int i = 0; i < tw; i++) begin
        logic [15:0] w;
        int sel;
        w = base + 16'(i) * STEP;
        sel = $urandom_range(0, 19);
        if (sel == 0) w = 16'($urandom);
        else if (sel == 1) w = 16'h0000;
        wdata.push_back(w);
      end
      model(ec, fidx, fexp, fact);
      fast = 1'b0;
      foreach (wdata[i]) src.push_back(wdata[i]);
      rd0 = rd_cnt; d0 = done_cnt; mon_chk = 1'b1;
      do_start(tw);
      finish_run(nm, tw, ec, (ec != 0) ? 1 : 0, rd0, d0, 1'b0);
`ifdef DATA_ERR_LOG_EN
      check({nm, "_fidx"}, first_err_idx, 32'(fidx));
      check({nm, "_fexp"}, 32'(first_err_exp), 32'(fexp));
      check({nm, "_fact"}, 32'(first_err_act), 32'(fact));
`endif
    end
  endtask

  task automatic sat_seq();
    int t = 0;
    rst2 = 1'b1; start2 = 1'b0; tw2 = 32'd0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk); tw2 = 32'd65600; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (wc2 < 32'd40000 && t < 80000) begin
      @(negedge clk);
      t++;
    end
    check("sat_mid_relation", 32'(ec2), wc2 - 32'd1);
    while (!done2 && t < 80000) begin
      @(negedge clk);
      t++;
    end
    check("sat_done", 32'(done2), 32'd1);
    check("sat_err_cnt", 32'(ec2), 32'h0000FFFF);
    check("sat_word_cnt", wc2, 32'd65600);
    check("sat_err", 32'(err2), 32'd1);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
